instr_sequencer: RTL

//  Upstream feeder for the processor control unit. Buffers 9-bit instructions
//  {op[8:6], ra[5:3], rb[2:0]} in a small FIFO, presents one on instr, and

---
 rtl/instr_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_sequencer                                               |
// | Purpose  : Instruction FIFO and step sequencer that feeds the processor  |
// |            control unit. It buffers 9-bit instructions {op,ra,rb}. It    |
// |            issues them one at a time with a 2-bit step count (00..11),   |
// |            back-to-back with no bubble. Undefined opcodes (011, 110) are |
// |            dropped.                                                      |
// | Ports    : clock    - rising-edge clock                                  |
// |            resetn   - asynchronous reset, active-high (1 = reset)        |
// |            din      - instruction to enqueue                             |
// |            in_valid - din valid; push when in_valid & in_ready           |
// |            in_ready - FIFO has room                                      |
// |            flush    - synchronous: empty FIFO, abort current instruction |
// |            hold     - stall: freeze count and issue                      |
// |            instr    - current instruction to the control unit            |
// |            count    - execution step to the control unit                 |
// |            busy     - an instruction is executing                        |
// |            done     - last step of the current instruction completes     |
// |            illegal  - 1-cycle pulse: undefined opcode popped and dropped |
// |            level    - FIFO occupancy                                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module instr_sequencer #(
  parameter int IW    = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [IW-1:0]            din,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     hold,
  output logic [IW-1:0]            instr,
  output logic [1:0]               count,
  output logic                     busy,
  output logic                     done,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [1:0]      count_q, count_d;
  logic            busy_q, busy_d;
  logic            illegal_q, illegal_d;
  logic [LW-1:0]   level_q, level_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]   mem_q [DEPTH];

  logic [IW-1:0]   head;
  logic            head_illegal;
  logic            push;
  logic            wr_en;
  logic            pop;
  logic            boundary;

  assign head         = mem_q[rd_ptr_q];
  assign head_illegal = (head[IW-1:IW-3] == 3'b011) || (head[IW-1:IW-3] == 3'b110);
  assign in_ready     = (level_q < LW'(DEPTH));
  assign push         = in_valid & in_ready;
  // A flush discards any same-cycle push, so the storage write is gated too.
  assign wr_en        = push & ~flush;
  // Issue decision point: idle, or the final step of the running instruction.
  assign boundary     = ~hold & ((state_q == IDLE) | (count_q == 2'b11));

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    count_d   = count_q;
    busy_d    = busy_q;
    illegal_d = 1'b0;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    level_d   = level_q;
    pop       = 1'b0;

    if (flush) begin
      // instr keeps its last value; everything else returns to idle.
      state_d  = IDLE;
      count_d  = 2'b00;
      busy_d   = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (boundary) begin
        if (level_q != '0) begin
          pop      = 1'b1;
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (head_illegal) begin
            // Dropped entry: behave as though the FIFO were empty this cycle;
            // the next entry is considered on the following cycle.
            illegal_d = 1'b1;
            state_d   = IDLE;
            busy_d    = 1'b0;
            count_d   = 2'b00;
          end else begin
            instr_d = head;
            count_d = 2'b00;
            busy_d  = 1'b1;
            state_d = EXEC;
          end
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          count_d = 2'b00;
        end
      end else if ((state_q == EXEC) && !hold) begin
        count_d = count_q + 2'b01;
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      count_q   <= 2'b00;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
      level_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_d;
      level_q   <= level_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Storage needs no reset: level and the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign instr   = instr_q;
  assign count   = count_q;
  assign busy    = busy_q;
  assign illegal = illegal_q;
  assign level   = level_q;
  assign done    = busy_q & (count_q == 2'b11) & ~hold;

endmodule
`default_nettype wire
